uart_rx_fifo: RTL

//  Oversampling UART receiver with a buffered output, for the tester's serial-port channels.

---
 rtl/uart_rx_fifo_if.sv | 20 ++
 rtl/uart_rx_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Receive-side stream between the UART receiver FIFO (master) and its consumer (slave).
// The master presents a first-word-fall-through entry. The slave pops it with m_ready.
interface uart_rx_fifo_if;
    logic [7:0] m_data;
    logic       m_parity_err;
    logic       m_framing_err;
    logic       m_break;
    logic       m_valid;
    logic       m_ready;

    modport master (
        output m_data, m_parity_err, m_framing_err, m_break, m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data, m_parity_err, m_framing_err, m_break, m_valid,
        output m_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with 3-sample majority voting, feeding a FWFT FIFO.
// Everything runs on clk; the divisor only produces a tick enable.
module uart_rx_fifo #(
    parameter int DIV_WIDTH  = 16,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    input  logic [1:0]                  dataBits,
    input  logic                        hasParity,
    input  logic [1:0]                  parityMode,
    input  logic                        extraStopBit,
    input  logic [DIV_WIDTH-1:0]        clockDivisor,
    uart_rx_fifo_if.master              m_if,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    input  logic                        clear_overflow
);
    localparam int BW = $clog2(OVERSAMPLE);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] SAMP_A   = BW'(OVERSAMPLE/2 - 1);
    localparam logic [BW-1:0] SAMP_B   = BW'(OVERSAMPLE/2);
    localparam logic [BW-1:0] SAMP_C   = BW'(OVERSAMPLE/2 + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, PUSH, BRKWAIT} state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [1:0]           dbits_q, dbits_d;
    logic                 has_par_q, has_par_d;
    logic [1:0]           par_mode_q, par_mode_d;
    logic                 two_stop_q, two_stop_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           data_q, data_d;
    logic                 par_bit_q, par_bit_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;
    logic                 tick, decide, maj, ones, push;

    assign tick = (state_q != IDLE) && (tick_cnt_q == div_q);
    assign maj  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign ones = (^data_q) ^ maj;

    always_comb begin
        state_d    = state_q;
        dbits_d    = dbits_q;
        has_par_d  = has_par_q;
        par_mode_d = par_mode_q;
        two_stop_d = two_stop_q;
        div_d      = div_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        samp_d     = samp_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        par_bit_d  = par_bit_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        brk_d      = brk_q;
        push       = 1'b0;
        decide     = 1'b0;

        if (tick) begin
            tick_cnt_d = '0;
            bit_cnt_d  = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
            if (bit_cnt_q == SAMP_A) samp_d[0] = rx_s_q;
            if (bit_cnt_q == SAMP_B) samp_d[1] = rx_s_q;
            if (bit_cnt_q == SAMP_C) decide = 1'b1;
        end else if (state_q != IDLE) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!rx_s_q) begin
                    state_d    = START;
                    dbits_d    = dataBits;
                    has_par_d  = hasParity;
                    par_mode_d = parityMode;
                    two_stop_d = extraStopBit;
                    div_d      = clockDivisor;
                    bit_idx_d  = '0;
                    data_d     = '0;
                    par_bit_d  = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    brk_d      = 1'b0;
                end
            end
            START: if (decide) state_d = maj ? IDLE : DATA;
            DATA: begin
                if (decide) begin
                    data_d[bit_idx_q] = maj;
                    bit_idx_d = bit_idx_q + 1'b1;
                    // Last data index is dataBits+4, i.e. {1, dataBits}
                    if (bit_idx_q == {1'b1, dbits_q}) state_d = has_par_q ? PARITY : STOP1;
                end
            end
            PARITY: begin
                if (decide) begin
                    par_bit_d = maj;
                    case (par_mode_q)
                        2'b00:   perr_d = maj;
                        2'b11:   perr_d = ~maj;
                        2'b10:   perr_d = ones;
                        default: perr_d = ~ones;
                    endcase
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (decide) begin
                    if (maj) begin
                        state_d = two_stop_q ? STOP2 : PUSH;
                    end else if (data_q == 8'd0 && !par_bit_q) begin
                        brk_d   = 1'b1;
                        perr_d  = 1'b0;
                        state_d = PUSH;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = PUSH;
                    end
                end
            end
            STOP2: begin
                if (decide) begin
                    ferr_d  = ~maj;
                    state_d = PUSH;
                end
            end
            PUSH: begin
                push    = 1'b1;
                state_d = brk_q ? BRKWAIT : IDLE;
            end
            BRKWAIT: if (rx_s_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= IDLE;
            dbits_q    <= '0;
            has_par_q  <= 1'b0;
            par_mode_q <= '0;
            two_stop_q <= 1'b0;
            div_q      <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            samp_q     <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            dbits_q    <= dbits_d;
            has_par_q  <= has_par_d;
            par_mode_q <= par_mode_d;
            two_stop_q <= two_stop_d;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            samp_q     <= samp_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            par_bit_q  <= par_bit_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
        end
    end

    logic [10:0]   mem [FIFO_DEPTH];
    logic [10:0]   wr_data, rd_data_q;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          full, pop, wr_en;

    assign full    = (count_q == (PW+1)'(FIFO_DEPTH));
    assign pop     = m_if.m_ready && (count_q != '0);
    assign wr_en   = push && (!full || pop);
    assign wr_data = {brk_q, ferr_q, perr_q, data_q};

    always_comb begin
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop)      count_d = count_q + 1'b1;
        else if (!wr_en && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_data;
    end

    // Head register reads one entry ahead; bypass when the word being written becomes the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= (wr_en && wr_ptr_q == rd_ptr_d) ? wr_data : mem[rd_ptr_d];
            if (push && full && !pop) overflow <= 1'b1;
            else if (clear_overflow)  overflow <= 1'b0;
        end
    end

    assign m_if.m_data        = rd_data_q[7:0];
    assign m_if.m_parity_err  = rd_data_q[8];
    assign m_if.m_framing_err = rd_data_q[9];
    assign m_if.m_break       = rd_data_q[10];
    assign m_if.m_valid       = (count_q != '0);
    assign fifo_level         = count_q;
endmodule
